// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared encodings and default address map for the load/store unit.
//   - req_size encodings (SZ_B, SZ_H, SZ_W; 2'b11 is also treated as word)
//   - fault cause encodings (CAUSE_NONE, CAUSE_MISALIGN, CAUSE_OOR)
//   - default DMEM / UART address constants
//   - load_extend(): shifts-down result -> zero/sign-extended load value
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_OOR      = 2'b10;

    localparam logic [31:0] DMEM_BASE_DEFAULT    = 32'h1000_0000;
    localparam int          DMEM_BYTES_DEFAULT   = 131072;
    localparam logic [31:0] UART_TX_ADDR_DEFAULT = 32'h2000_0000;
    localparam int          UART_DEPTH_DEFAULT   = 4;

    // raw already has the addressed byte/half moved down to bit 0.
    function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                                input logic [1:0]  size,
                                                input logic        sgn);
        logic [31:0] res;
        case (size)
            SZ_B:    res = sgn ? {{24{raw[7]}}, raw[7:0]}   : {24'b0, raw[7:0]};
            SZ_H:    res = sgn ? {{16{raw[15]}}, raw[15:0]} : {16'b0, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_dmem_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Byte FIFO buffering UART TX data between the LSU and the UART consumer.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (pointers/count only)
//   push, din      write din when push (ignored when full)
//   pop            drop head (ignored when empty)
//   full, empty    occupancy flags
//   head           current head byte, 0 while empty
//   count          number of stored entries
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [7:0]                 din,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [7:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head is forced to 0 when empty so stale storage never leaks out after reset.
    assign head    = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lsu_dmem.sv
// -----------------------------------------------------------------------------
// lsu_dmem
// MEM-stage load/store unit: byte-addressable DMEM (4 byte lanes), a UART TX
// data/status MMIO window backed by a TX FIFO, and fault reporting for
// misaligned / out-of-range accesses. Every accepted request gets one
// registered response on the following cycle.
// Optional feature macro: LSU_FAULT_CAPTURE_EN (sticky first-fault address).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_we, req_addr           store flag, effective address
//   req_wdata                  LSB-aligned store data
//   req_size, req_signed       access size, sign-extend loads
//   resp_valid                 one-cycle response pulse
//   resp_rdata                 extended load data (0 for stores / faults)
//   resp_fault, resp_cause     fault flag and cause
//   uart_tx_valid/data/ready   FIFO drain port
//   fault_addr, fault_clr      first-fault capture (0 / ignored when disabled)
// -----------------------------------------------------------------------------
module lsu_dmem
    import lsu_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE       = DMEM_BASE_DEFAULT,
    parameter int          DMEM_BYTES      = DMEM_BYTES_DEFAULT,
    parameter logic [31:0] UART_TX_ADDR    = UART_TX_ADDR_DEFAULT,
    parameter int          UART_FIFO_DEPTH = UART_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [1:0]  resp_cause,
    output logic        uart_tx_valid,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_ready,
    output logic [31:0] fault_addr,
    input  logic        fault_clr
);

    localparam int          WORDS          = DMEM_BYTES / 4;
    localparam int          IDX_W          = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [31:0] UART_STAT_ADDR = UART_TX_ADDR + 32'd4;

    logic [31:0]      offset;
    logic             in_dmem;
    logic             is_uart_data;
    logic             is_uart_stat;
    logic [IDX_W-1:0] word_idx;
    logic             misalign;
    logic             oor;
    logic             req_fault;
    logic [1:0]       req_cause;
    logic             accept;
    logic             dmem_we;
    logic [3:0]       be;
    logic [31:0]      wdata_sh;
    logic [31:0]      rword;
    logic [31:0]      load_val;
    logic [31:0]      rdata_next;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [$clog2(UART_FIFO_DEPTH+1)-1:0] unused_fifo_count;

    // ---------------- address decode and fault classification ----------------
    // Unsigned wrap of the subtraction makes addresses below the base fall out of range too.
    assign offset       = req_addr - DMEM_BASE;
    assign in_dmem      = (offset < 32'(DMEM_BYTES));
    assign word_idx     = offset[IDX_W+1:2];
    assign is_uart_data = (req_addr == UART_TX_ADDR);
    assign is_uart_stat = (req_addr == UART_STAT_ADDR);

    assign misalign = ((req_size == SZ_H) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
    assign oor      = req_we ? !(in_dmem || is_uart_data)
                             : !(in_dmem || is_uart_stat);

    always_comb begin
        req_fault = 1'b0;
        req_cause = CAUSE_NONE;
        if (misalign) begin
            req_fault = 1'b1;
            req_cause = CAUSE_MISALIGN;
        end else if (oor) begin
            req_fault = 1'b1;
            req_cause = CAUSE_OOR;
        end
    end

    // Only a store to a full UART FIFO back-pressures; a same-cycle pop does not help.
    assign req_ready = !(req_we && is_uart_data && fifo_full);
    assign accept    = req_valid && req_ready;

    // ---------------- DMEM lanes ----------------
    always_comb begin
        case (req_size)
            SZ_B:    be = 4'b0001 << req_addr[1:0];
            SZ_H:    be = 4'b0011 << {req_addr[1], 1'b0};
            default: be = 4'b1111;
        endcase
    end

    assign wdata_sh = req_wdata << {req_addr[1:0], 3'b000};
    assign dmem_we  = accept && req_we && !req_fault && in_dmem;

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem [WORDS];

        always_ff @(posedge clk) begin
            if (dmem_we && be[l]) begin
                mem[word_idx] <= wdata_sh[8*l +: 8];
            end
        end

        assign rword[8*l +: 8] = mem[word_idx];
    end

    assign load_val = load_extend(rword >> {req_addr[1:0], 3'b000}, req_size, req_signed);

    always_comb begin
        rdata_next = 32'h0;
        if (!req_fault && !req_we) begin
            if (is_uart_stat) begin
                rdata_next = {30'b0, fifo_full, fifo_empty};
            end else begin
                rdata_next = load_val;
            end
        end
    end

    // ---------------- response register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_fault <= 1'b0;
            resp_cause <= CAUSE_NONE;
        end else begin
            resp_valid <= accept;
            resp_rdata <= accept ? rdata_next : 32'h0;
            resp_fault <= accept && req_fault;
            resp_cause <= accept ? req_cause : CAUSE_NONE;
        end
    end

    // ---------------- UART TX FIFO ----------------
    assign fifo_push     = accept && req_we && is_uart_data && !req_fault;
    assign fifo_pop      = uart_tx_valid && uart_tx_ready;
    assign uart_tx_valid = !fifo_empty;

    uart_tx_fifo #(
        .DEPTH (UART_FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (req_wdata[7:0]),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (uart_tx_data),
        .count (unused_fifo_count)
    );

    // ---------------- optional first-fault capture ----------------
`ifdef LSU_FAULT_CAPTURE_EN
    logic        captured;
    logic [31:0] fault_addr_q;

    // Clear has priority over a simultaneous new fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            captured     <= 1'b0;
            fault_addr_q <= 32'h0;
        end else if (fault_clr) begin
            captured     <= 1'b0;
            fault_addr_q <= 32'h0;
        end else if (accept && req_fault && !captured) begin
            captured     <= 1'b1;
            fault_addr_q <= req_addr;
        end
    end

    assign fault_addr = fault_addr_q;
`else
    logic unused_fault_clr;

    assign fault_addr       = 32'h0;
    assign unused_fault_clr = fault_clr;
`endif

endmodule

// File: tb/tb_lsu_dmem.sv
// -----------------------------------------------------------------------------
// tb_lsu_dmem
// Directed testbench for lsu_dmem: DMEM store/load with extension, faults,
// UART FIFO fill/back-pressure/drain, load-after-store, reset mid-operation
// and (when LSU_FAULT_CAPTURE_EN is defined) first-fault capture.
// Inputs change on the falling edge; outputs are sampled 1ns after the rising
// edge or on the falling edge.
// -----------------------------------------------------------------------------
module tb_lsu_dmem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [1:0]  resp_cause;
    logic        uart_tx_valid;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_ready;
    logic [31:0] fault_addr;
    logic        fault_clr;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lsu_dmem dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_size      (req_size),
        .req_signed    (req_signed),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_fault    (resp_fault),
        .resp_cause    (resp_cause),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_ready (uart_tx_ready),
        .fault_addr    (fault_addr),
        .fault_clr     (fault_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request on the falling edge, let it be accepted on the next
    // rising edge, then check the registered response 1ns later.
    task automatic access(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size, input logic sgn,
                          input logic exp_fault, input logic [1:0] exp_cause,
                          input logic [31:0] exp_rdata);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_size   = size;
        req_signed = sgn;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check({tag, ".valid"}, 32'(resp_valid), 32'd1);
        check({tag, ".fault"}, 32'(resp_fault), 32'(exp_fault));
        check({tag, ".cause"}, 32'(resp_cause), 32'(exp_cause));
        check({tag, ".rdata"}, resp_rdata, exp_rdata);
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_we        = 1'b0;
        req_addr      = 32'h0;
        req_wdata     = 32'h0;
        req_size      = 2'b00;
        req_signed    = 1'b0;
        uart_tx_ready = 1'b0;
        fault_clr     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'h0);
        check("rst.resp_fault", 32'(resp_fault), 32'd0);
        check("rst.tx_valid", 32'(uart_tx_valid), 32'd0);
        check("rst.tx_data", 32'(uart_tx_data), 32'd0);
        check("rst.fault_addr", fault_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // DMEM store, then loads with extension
        access("sw4",   1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0, 2'b00, 32'h0);
        access("lb7s",  1'b0, 32'h1000_0007, 32'h0,         2'b00, 1'b1, 1'b0, 2'b00, 32'hFFFF_FFDE);
        access("lhu4",  1'b0, 32'h1000_0004, 32'h0,         2'b01, 1'b0, 1'b0, 2'b00, 32'h0000_BEEF);
        access("lw4",   1'b0, 32'h1000_0004, 32'h0,         2'b10, 1'b0, 1'b0, 2'b00, 32'hDEAD_BEEF);
        access("lbu5",  1'b0, 32'h1000_0005, 32'h0,         2'b00, 1'b0, 1'b0, 2'b00, 32'h0000_00BE);

        // Faults
        access("lw2mis", 1'b0, 32'h1000_0002, 32'h0,         2'b10, 1'b0, 1'b1, 2'b01, 32'h0);
        access("sw6mis", 1'b1, 32'h1000_0006, 32'h1111_1111, 2'b10, 1'b0, 1'b1, 2'b01, 32'h0);
        access("lw4keep",1'b0, 32'h1000_0004, 32'h0,         2'b10, 1'b0, 1'b0, 2'b00, 32'hDEAD_BEEF);
        access("sboor",  1'b1, 32'h3000_0000, 32'h55,        2'b00, 1'b0, 1'b1, 2'b10, 32'h0);
        access("lwuart", 1'b0, 32'h2000_0000, 32'h0,         2'b10, 1'b0, 1'b1, 2'b10, 32'h0);
        access("lhlast", 1'b0, 32'h1002_0000, 32'h0,         2'b01, 1'b0, 1'b1, 2'b10, 32'h0);
        check("oor.tx_valid", 32'(uart_tx_valid), 32'd0);

        // Back-to-back store/load and half-word lanes
        access("sw10",  1'b1, 32'h1000_0010, 32'h1234_5678, 2'b10, 1'b0, 1'b0, 2'b00, 32'h0);
        access("lw10",  1'b0, 32'h1000_0010, 32'h0,         2'b10, 1'b0, 1'b0, 2'b00, 32'h1234_5678);
        access("sh12",  1'b1, 32'h1000_0012, 32'h0000_8001, 2'b01, 1'b0, 1'b0, 2'b00, 32'h0);
        access("lh12s", 1'b0, 32'h1000_0012, 32'h0,         2'b01, 1'b1, 1'b0, 2'b00, 32'hFFFF_8001);
        access("lbu13", 1'b0, 32'h1000_0013, 32'h0,         2'b00, 1'b0, 1'b0, 2'b00, 32'h0000_0080);
        access("lhu10", 1'b0, 32'h1000_0010, 32'h0,         2'b01, 1'b0, 1'b0, 2'b00, 32'h0000_5678);
        access("sb11",  1'b1, 32'h1000_0011, 32'h0000_00A5, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
        access("lw10b", 1'b0, 32'h1000_0010, 32'h0,         2'b11, 1'b0, 1'b0, 2'b00, 32'h8001_A578);

        // UART fill, back-pressure, status, drain
        access("stA", 1'b1, 32'h2000_0000, 32'h41, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
        access("stB", 1'b1, 32'h2000_0000, 32'h42, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
        access("stC", 1'b1, 32'h2000_0000, 32'h43, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
        access("stD", 1'b1, 32'h2000_0000, 32'h44, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h2000_0000;
        req_wdata = 32'h45;
        req_size  = 2'b00;
        #1;
        check("st5.ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("st5.resp_valid", 32'(resp_valid), 32'd0);
        access("stat_full", 1'b0, 32'h2000_0004, 32'h0, 2'b10, 1'b0, 1'b0, 2'b00, 32'h0000_0002);
        check("fill.tx_valid", 32'(uart_tx_valid), 32'd1);

        @(negedge clk);
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d.data", i), 32'(uart_tx_data), 32'h41 + 32'(i));
            @(negedge clk);
        end
        uart_tx_ready = 1'b0;
        check("drain.tx_valid", 32'(uart_tx_valid), 32'd0);
        access("stat_empty", 1'b0, 32'h2000_0004, 32'h0, 2'b10, 1'b0, 1'b0, 2'b00, 32'h0000_0001);

        // Reset while a response is pending and the FIFO holds data
        access("stZ", 1'b1, 32'h2000_0000, 32'h5A, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
        access("ldpend", 1'b0, 32'h1000_0004, 32'h0, 2'b10, 1'b0, 1'b0, 2'b00, 32'hDEAD_BEEF);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst.resp_valid", 32'(resp_valid), 32'd0);
        check("arst.resp_rdata", resp_rdata, 32'h0);
        check("arst.tx_valid", 32'(uart_tx_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel.tx_valid", 32'(uart_tx_valid), 32'd0);
        check("rel.tx_data", 32'(uart_tx_data), 32'd0);
        check("rel.resp_valid", 32'(resp_valid), 32'd0);
        access("lwkeep", 1'b0, 32'h1000_0004, 32'h0, 2'b10, 1'b0, 1'b0, 2'b00, 32'hDEAD_BEEF);

        // First-fault capture
        access("fa1", 1'b0, 32'h1000_0001, 32'h0, 2'b01, 1'b0, 1'b1, 2'b01, 32'h0);
`ifdef LSU_FAULT_CAPTURE_EN
        check("cap.first", fault_addr, 32'h1000_0001);
        access("fa2", 1'b0, 32'h4000_0000, 32'h0, 2'b10, 1'b0, 1'b1, 2'b10, 32'h0);
        check("cap.sticky", fault_addr, 32'h1000_0001);
        @(negedge clk);
        fault_clr = 1'b1;
        @(posedge clk);
        #1;
        fault_clr = 1'b0;
        check("cap.clr", fault_addr, 32'h0);
        access("fa3", 1'b0, 32'h4000_0000, 32'h0, 2'b10, 1'b0, 1'b1, 2'b10, 32'h0);
        check("cap.recap", fault_addr, 32'h4000_0000);
`else
        check("nocap.addr", fault_addr, 32'h0);
        @(negedge clk);
        fault_clr = 1'b1;
        @(posedge clk);
        #1;
        fault_clr = 1'b0;
        check("nocap.clr", fault_addr, 32'h0);
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
